// File: rtl/i2c_resp_target.sv
// i2c_resp_target: I2C target responder. Oversamples SCL/SDA on clk, detects
// START/STOP, matches a 7-bit address, ACKs every written byte and shifts out
// host-supplied read bytes. Optional macro I2C_RESP_GLITCH_FILTER_EN inserts a
// 3-sample majority filter after each synchronizer (+2 clk detection latency).
module i2c_resp_target #(
  parameter int unsigned               I2C_ADDR_WIDTH = 7,
  parameter int unsigned               I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR    = 7'h22
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_oe,
  output logic [I2C_DATA_WIDTH-1:0] wr_data,
  output logic                      wr_valid,
  output logic                      rd_req,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data,
  output logic                      busy,
  output logic                      start_det,
  output logic                      stop_det
);

  localparam int unsigned      CNT_W    = 3;
  localparam int unsigned      MSB      = I2C_DATA_WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(I2C_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
  } state_t;

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       w_scl;
  logic       w_sda;
  logic       r_scl_d;
  logic       r_sda_d;
  logic       r_scl_rise;
  logic       r_scl_fall;
  logic       r_start;
  logic       r_stop;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [I2C_DATA_WIDTH-1:0] r_shift;
  logic [I2C_DATA_WIDTH-1:0] w_shift_nxt;
  logic [I2C_DATA_WIDTH-1:0] w_shift_in;
  logic [CNT_W-1:0]          r_bit_cnt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic                      r_ack_phase;
  logic                      w_phase_nxt;
  logic                      r_sda_oe;
  logic                      w_oe_nxt;
  logic [I2C_DATA_WIDTH-1:0] r_wr_data;
  logic [I2C_DATA_WIDTH-1:0] w_wr_data_nxt;
  logic                      r_wr_valid;
  logic                      w_wr_valid_nxt;
  logic                      r_rd_req;
  logic                      w_rd_req_nxt;
  logic                      r_busy;
  logic                      w_busy_nxt;
  logic                      w_addr_match;

  // Two-flop synchronizers; idle bus level is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_i};
      r_sda_sync <= {r_sda_sync[0], sda_i};
    end
  end

`ifdef I2C_RESP_GLITCH_FILTER_EN
  logic [2:0] r_scl_hist;
  logic [2:0] r_sda_hist;

  // Majority-of-three history rejects single-sample pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_hist <= 3'b111;
      r_sda_hist <= 3'b111;
    end else begin
      r_scl_hist <= {r_scl_hist[1:0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[1:0], r_sda_sync[1]};
    end
  end

  assign w_scl = (r_scl_hist[0] & r_scl_hist[1]) | (r_scl_hist[0] & r_scl_hist[2]) |
                 (r_scl_hist[1] & r_scl_hist[2]);
  assign w_sda = (r_sda_hist[0] & r_sda_hist[1]) | (r_sda_hist[0] & r_sda_hist[2]) |
                 (r_sda_hist[1] & r_sda_hist[2]);
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  // Edge register: registered one-cycle bus event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      r_scl_rise <= w_scl & ~r_scl_d;
      r_scl_fall <= ~w_scl & r_scl_d;
      r_start    <= w_scl & r_scl_d & r_sda_d & ~w_sda;
      r_stop     <= w_scl & r_scl_d & ~r_sda_d & w_sda;
    end
  end

  // r_sda_d is the settled SDA level in the cycle a rise pulse is seen
  assign w_shift_in   = {r_shift[MSB-1:0], r_sda_d};
  assign w_addr_match = (w_shift_in[MSB -: I2C_ADDR_WIDTH] == TARGET_ADDR);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; STOP outranks START, both outrank SCL events
  always_comb begin
    w_state_nxt = r_state;
    if (r_stop) begin
      w_state_nxt = S_IDLE;
    end else if (r_start) begin
      w_state_nxt = S_ADDR;
    end else begin
      case (r_state)
        S_ADDR:
          if (r_scl_rise && r_bit_cnt == LAST_BIT)
            w_state_nxt = w_addr_match ? S_ADDR_ACK : S_WAIT_STOP;
        S_ADDR_ACK:
          if (r_scl_fall && r_ack_phase)
            w_state_nxt = r_shift[0] ? S_RD_BYTE : S_WR_BYTE;
        S_WR_BYTE:
          if (r_scl_rise && r_bit_cnt == LAST_BIT) w_state_nxt = S_WR_ACK;
        S_WR_ACK:
          if (r_scl_fall && r_ack_phase) w_state_nxt = S_WR_BYTE;
        S_RD_BYTE:
          if (r_scl_fall && r_bit_cnt == LAST_BIT) w_state_nxt = S_RD_ACK;
        S_RD_ACK:
          if (r_scl_rise && r_sda_d)               w_state_nxt = S_WAIT_STOP;
          else if (r_scl_fall && r_ack_phase)      w_state_nxt = S_RD_BYTE;
        default: ;
      endcase
    end
  end

  // Output/datapath next values
  always_comb begin
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_bit_cnt;
    w_phase_nxt    = r_ack_phase;
    w_oe_nxt       = r_sda_oe;
    w_wr_data_nxt  = r_wr_data;
    w_wr_valid_nxt = 1'b0;
    w_rd_req_nxt   = 1'b0;
    w_busy_nxt     = r_busy;
    // Host byte is captured at the end of the rd_req cycle
    if (r_rd_req) begin
      w_shift_nxt = rd_data;
      w_oe_nxt    = ~rd_data[MSB];
    end
    if (r_stop) begin
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b0;
    end else if (r_start) begin
      w_oe_nxt    = 1'b0;
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b0;
    end else begin
      case (r_state)
        S_ADDR:
          if (r_scl_rise) begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == LAST_BIT) w_busy_nxt = w_addr_match;
          end
        S_ADDR_ACK:
          if (r_scl_fall) begin
            if (!r_ack_phase) begin
              w_oe_nxt    = 1'b1;
              w_phase_nxt = 1'b1;
            end else begin
              w_oe_nxt     = 1'b0;
              w_phase_nxt  = 1'b0;
              w_rd_req_nxt = r_shift[0];
              w_cnt_nxt    = '0;
            end
          end
        S_WR_BYTE:
          if (r_scl_rise) begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = r_bit_cnt + CNT_W'(1);
          end
        S_WR_ACK:
          if (r_scl_fall) begin
            if (!r_ack_phase) begin
              w_wr_data_nxt  = r_shift;
              w_wr_valid_nxt = 1'b1;
              w_oe_nxt       = 1'b1;
              w_phase_nxt    = 1'b1;
            end else begin
              w_oe_nxt    = 1'b0;
              w_phase_nxt = 1'b0;
            end
          end
        S_RD_BYTE:
          if (r_scl_fall) begin
            w_cnt_nxt = r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == LAST_BIT) begin
              w_oe_nxt = 1'b0;
            end else begin
              w_shift_nxt = {r_shift[MSB-1:0], 1'b0};
              w_oe_nxt    = ~r_shift[MSB-1];
            end
          end
        S_RD_ACK:
          if (r_scl_rise && !r_sda_d) begin
            w_phase_nxt = 1'b1;
          end else if (r_scl_fall && r_ack_phase) begin
            w_phase_nxt  = 1'b0;
            w_rd_req_nxt = 1'b1;
            w_cnt_nxt    = '0;
          end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_ack_phase <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_wr_data   <= '0;
      r_wr_valid  <= 1'b0;
      r_rd_req    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_cnt_nxt;
      r_ack_phase <= w_phase_nxt;
      r_sda_oe    <= w_oe_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_wr_valid  <= w_wr_valid_nxt;
      r_rd_req    <= w_rd_req_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // First read bit follows rd_data while rd_req is high, then comes from the register
  assign sda_oe    = r_rd_req ? ~rd_data[MSB] : r_sda_oe;
  assign wr_data   = r_wr_data;
  assign wr_valid  = r_wr_valid;
  assign rd_req    = r_rd_req;
  assign busy      = r_busy;
  assign start_det = r_start;
  assign stop_det  = r_stop;

endmodule

// File: tb/tb_i2c_resp_target.sv
// tb_i2c_resp_target: bit-level I2C master plus host model driving i2c_resp_target.
module tb_i2c_resp_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       rd_req;
  logic [7:0] rd_data = 8'hFF;
  logic       busy;
  logic       start_det;
  logic       stop_det;

  int checks = 0;
  int errors = 0;

  // Expected target drive while SCL is high
  logic exp_en = 1'b0;
  logic exp_oe = 1'b0;

  logic [7:0] wr_q[$];
  logic [7:0] rd_bytes[4];
  int         rd_idx = 0;
  int         n_wr = 0, n_rd = 0, n_start = 0, n_stop = 0;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_resp_target dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .busy      (busy),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: SDA drive during SCL high, written bytes, pulse counts
  always @(negedge clk) begin
    if (exp_en) chk("sda_oe", sda_oe, exp_oe);
    if (wr_valid) begin
      n_wr++;
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected actual=%0h required=none", wr_data);
      end else begin
        chk("wr_data", wr_data, wr_q.pop_front());
      end
    end
    if (rd_req)    n_rd++;
    if (start_det) n_start++;
    if (stop_det)  n_stop++;
  end

  // Host side: hold current byte through the rd_req cycle, then advance
  initial begin
    forever begin
      @(negedge clk);
      if (rd_req) begin
        @(posedge clk);
        #1;
        rd_idx  = rd_idx + 1;
        rd_data = rd_bytes[rd_idx % 4];
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_load(input logic [7:0] b0, input logic [7:0] b1);
    rd_bytes[0] = b0;
    rd_bytes[1] = b1;
    rd_bytes[2] = 8'hFF;
    rd_bytes[3] = 8'hFF;
    rd_idx      = 0;
    rd_data     = b0;
  endtask

  // One SCL period starting just after SCL fell; SDA changes late in the low phase
  task automatic m_bit(input logic drv, input logic oe_exp, output logic smp);
    clk_n(7);
    sda_m = drv;
    clk_n(3);
    scl_m  = 1'b1;
    exp_oe = oe_exp;
    exp_en = 1'b1;
    clk_n(5);
    smp = sda_bus;
    clk_n(5);
    exp_en = 1'b0;
    scl_m  = 1'b0;
  endtask

  task automatic m_start();
    if (!scl_m) begin
      clk_n(7);
      sda_m = 1'b1;
      clk_n(3);
      scl_m = 1'b1;
    end
    clk_n(5);
    sda_m = 1'b0;
    clk_n(5);
    scl_m = 1'b0;
  endtask

  task automatic m_stop();
    clk_n(7);
    sda_m = 1'b0;
    clk_n(3);
    scl_m = 1'b1;
    clk_n(5);
    sda_m = 1'b1;
    clk_n(10);
  endtask

  task automatic m_byte_wr(input string name, input logic [7:0] b, input logic ack_exp);
    logic smp;
    for (int i = 7; i >= 0; i--) m_bit(b[i], 1'b0, smp);
    m_bit(1'b1, ack_exp, smp);
    chk(name, smp, !ack_exp);
  endtask

  task automatic m_byte_rd(input string name, input logic [7:0] exp_b, input logic m_ack);
    logic       smp;
    logic [7:0] got;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, !exp_b[i], smp);
      got[i] = smp;
    end
    chk(name, got, exp_b);
    m_bit(!m_ack, 1'b0, smp);
  endtask

`ifdef I2C_RESP_GLITCH_FILTER_EN
  // Write byte with a one-clk low pulse on SCL inside the high phase of bit 3
  task automatic m_byte_wr_glitch(input logic [7:0] b);
    logic smp;
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) begin
        clk_n(7);
        sda_m = b[i];
        clk_n(3);
        scl_m  = 1'b1;
        exp_oe = 1'b0;
        exp_en = 1'b1;
        clk_n(4);
        scl_m = 1'b0;
        clk_n(1);
        scl_m = 1'b1;
        clk_n(5);
        exp_en = 1'b0;
        scl_m  = 1'b0;
      end else begin
        m_bit(b[i], 1'b0, smp);
      end
    end
    m_bit(1'b1, 1'b1, smp);
    chk("glitch_ack", smp, 1'b0);
  endtask
`endif

  initial begin
    int w0, r0, s0, p0;
    logic smp;

    // Reset values
    clk_n(3);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_rd_req", rd_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start_det", start_det, 1'b0);
    chk("rst_stop_det", stop_det, 1'b0);
    rst = 1'b0;
    clk_n(5);

    // Write 0x22/W, 0xA5, 0x3C, STOP
    w0 = n_wr; s0 = n_start; p0 = n_stop;
    m_start();
    m_byte_wr("t1_addr_ack", 8'h44, 1'b1);
    chk("t1_busy_on", busy, 1'b1);
    wr_q.push_back(8'hA5);
    m_byte_wr("t1_ack0", 8'hA5, 1'b1);
    wr_q.push_back(8'h3C);
    m_byte_wr("t1_ack1", 8'h3C, 1'b1);
    m_stop();
    chk("t1_wr_count", 32'(n_wr - w0), 2);
    chk("t1_start_count", 32'(n_start - s0), 1);
    chk("t1_stop_count", 32'(n_stop - p0), 1);
    chk("t1_busy_off", busy, 1'b0);
    chk("t1_wr_data", wr_data, 8'h3C);
    chk("t1_wr_q_empty", 32'(wr_q.size()), 0);

    // Read 0x22/R: 0x96 ACKed, 0x0F NACKed
    r0 = n_rd;
    host_load(8'h96, 8'h0F);
    m_start();
    m_byte_wr("t2_addr_ack", 8'h45, 1'b1);
    m_byte_rd("t2_rd0", 8'h96, 1'b1);
    m_byte_rd("t2_rd1", 8'h0F, 1'b0);
    chk("t2_busy_before_stop", busy, 1'b1);
    m_stop();
    chk("t2_rd_count", 32'(n_rd - r0), 2);
    chk("t2_busy_off", busy, 1'b0);

    // Address 0x23/W: no ACK, nothing written, not busy
    w0 = n_wr;
    m_start();
    m_byte_wr("t3_addr_nack", 8'h46, 1'b0);
    chk("t3_busy", busy, 1'b0);
    m_byte_wr("t3_data_nack", 8'h55, 1'b0);
    m_stop();
    chk("t3_wr_count", 32'(n_wr - w0), 0);

    // Write 0x11, repeated START, read 0x77
    s0 = n_start; r0 = n_rd;
    host_load(8'h77, 8'hFF);
    m_start();
    m_byte_wr("t4_addr_w_ack", 8'h44, 1'b1);
    wr_q.push_back(8'h11);
    m_byte_wr("t4_ack", 8'h11, 1'b1);
    m_start();
    m_byte_wr("t4_addr_r_ack", 8'h45, 1'b1);
    m_byte_rd("t4_rd", 8'h77, 1'b0);
    m_stop();
    chk("t4_start_count", 32'(n_start - s0), 2);
    chk("t4_rd_count", 32'(n_rd - r0), 1);
    chk("t4_wr_data", wr_data, 8'h11);

    // Reset during 4th bit of read byte 0xA0 (that bit is 0, so target pulls low)
    host_load(8'hA0, 8'hFF);
    m_start();
    m_byte_wr("t5_addr_ack", 8'h45, 1'b1);
    m_bit(1'b1, 1'b0, smp);
    m_bit(1'b1, 1'b1, smp);
    m_bit(1'b1, 1'b0, smp);
    clk_n(7);
    sda_m = 1'b1;
    clk_n(3);
    scl_m  = 1'b1;
    exp_oe = 1'b1;
    exp_en = 1'b1;
    clk_n(3);
    exp_en = 1'b0;
    chk("t5_oe_before_rst", sda_oe, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_oe_async_drop", sda_oe, 1'b0);
    chk("t5_busy_rst", busy, 1'b0);
    clk_n(3);
    rst = 1'b0;
    clk_n(4);
    scl_m = 1'b0;
    w0 = n_wr; r0 = n_rd; s0 = n_start;
    for (int i = 0; i < 5; i++) m_bit(1'b1, 1'b0, smp);
    m_byte_wr("t5_no_start_nack", 8'h44, 1'b0);
    chk("t5_ignored_rd", 32'(n_rd - r0), 0);
    chk("t5_ignored_start", 32'(n_start - s0), 0);
    m_stop();
    m_start();
    m_byte_wr("t5_after_addr_ack", 8'h44, 1'b1);
    wr_q.push_back(8'h5A);
    m_byte_wr("t5_after_ack", 8'h5A, 1'b1);
    m_stop();
    chk("t5_wr_count", 32'(n_wr - w0), 1);
    chk("t5_wr_data", wr_data, 8'h5A);

`ifdef I2C_RESP_GLITCH_FILTER_EN
    // One-clk SCL glitch inside a written byte is filtered out
    w0 = n_wr;
    m_start();
    m_byte_wr("t6_addr_ack", 8'h44, 1'b1);
    wr_q.push_back(8'hC3);
    m_byte_wr_glitch(8'hC3);
    m_stop();
    chk("t6_wr_count", 32'(n_wr - w0), 1);
    chk("t6_wr_data", wr_data, 8'hC3);
`endif

    chk("final_wr_q_empty", 32'(wr_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_resp_target.md
# i2c_resp_target

I2C target (slave) responder for a single bus, serving the far end of the Wishbone-to-I2C master controller. The block oversamples SCL/SDA on the system clock, recognises START/STOP, matches a 7-bit address, and hands written bytes to a host-side port. Read bytes are requested from the host-side port and shifted out on SDA. It is used as a synthesizable bus partner in the DUT-level integration bench, and as a reference model for the I2C agent.

## Interface
- I2C_ADDR_WIDTH, 7, target address width (fixed at 7; 10-bit addressing not supported)
- I2C_DATA_WIDTH, 8, byte width
- TARGET_ADDR, 7'h22, address this target responds to
- clk  input  1  system clock; must be ≥ 16× SCL frequency
- rst  input  1  asynchronous, active-high reset
- scl_i  input  1  SCL line as seen on the bus (asynchronous)
- sda_i  input  1  SDA line as seen on the bus (asynchronous)
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release
- wr_data  output  I2C_DATA_WIDTH  last byte written by the master
- wr_valid  output  1  one-cycle pulse; wr_data is valid
- rd_req  output  1  one-cycle pulse; host must present rd_data in the same cycle
- rd_data  input  I2C_DATA_WIDTH  byte to transmit; sampled while rd_req = 1
- busy  output  1  1 from an addressed START until STOP or address mismatch
- start_det  output  1  one-cycle pulse per START or repeated START
- stop_det  output  1  one-cycle pulse per STOP

## Operation
- Input path: each line passes through a 2-flop synchronizer and then an edge detector. scl_rise, scl_fall, START (SDA falls while SCL = 1) and STOP (SDA rises while SCL = 1) are derived from the synchronized values.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- IDLE: waits for START, then goes to ADDR.
- ADDR: shifts 8 bits, MSB first, on each scl_rise (7 address bits + R/W).
  - After the 8th rise, if the address equals TARGET_ADDR, go to ADDR_ACK.
  - Otherwise go to WAIT_STOP with SDA released.
- ADDR_ACK: on the next scl_fall, drive sda_oe = 1. On the following scl_fall, release SDA.
  - R/W = 0: go to WR_BYTE.
  - R/W = 1: pulse rd_req, load rd_data into the shift register, drive its MSB, and go to RD_BYTE.
- WR_BYTE: shifts 8 bits on scl_rise. After the 8th bit, go to WR_ACK.
- WR_ACK: on the scl_fall after the 8th bit, update wr_data, pulse wr_valid, and assert sda_oe. Release on the next scl_fall and return to WR_BYTE. Every byte is ACKed.
- RD_BYTE: on each scl_fall, set sda_oe = ~current bit. After 8 bits, release SDA and go to RD_ACK.
- RD_ACK: samples SDA on scl_rise.
  - ACK (0): on the next scl_fall, pulse rd_req, reload, and go to RD_BYTE.
  - NACK (1): go to WAIT_STOP.
- WAIT_STOP: SDA released; ignores traffic until STOP or START.
- START (including repeated START) in any state: resets the bit counter, pulses start_det, goes to ADDR, and releases SDA.
- STOP in any state: pulses stop_det, goes to IDLE, releases SDA, and clears busy.
- Bit counter: 3 bits, wraps 7→0 at each byte boundary.

## Timing
- Reset values: sda_oe = 0, wr_data = 0, wr_valid = 0, rd_req = 0, busy = 0, start_det = 0, stop_det = 0. State is IDLE.
- Reset asserted mid-transfer: sda_oe drops asynchronously and immediately. The block returns to IDLE and ignores the bus until the next START.
- Detection latency: a bus edge is recognised 3 clk after it occurs (2 synchronizer flops + 1 edge register).
- sda_oe changes 1 clk after the detected scl_fall, i.e. 4 clk after the actual SCL falling edge.
- start_det and stop_det pulse in the detection cycle. wr_valid and rd_req pulse in the same cycle that sda_oe updates.
- STOP and scl_fall in the same cycle: STOP wins.
- START while SDA is driven low by the target is not detectable; that is a bus protocol violation and is not handled.
- busy rises in the cycle ADDR_ACK is entered.

## Configuration
- I2C_RESP_GLITCH_FILTER_EN defined: adds a 3-sample majority filter after each synchronizer. Pulses of 1 clk on SCL/SDA are rejected, and all detection latencies grow by 2 clk (edge recognised 5 clk after the bus edge).
- I2C_RESP_GLITCH_FILTER_EN undefined: no filter. Latencies are as stated under Timing.

## Test plan
- Write 0x22/W followed by bytes 0xA5, 0x3C, then STOP -> address ACK and two data ACKs on SDA; wr_valid pulses twice with wr_data = 0xA5 then 0x3C; stop_det pulses once; busy returns to 0.
- Read 0x22/R; host supplies 0x96 then 0x0F; master ACKs the first byte and NACKs the second -> SDA carries 1001_0110 then 0000_1111; rd_req pulses exactly twice; the block enters WAIT_STOP and then IDLE on STOP.
- Address 0x23/W -> no ACK (SDA stays high on the 9th clock); wr_valid is never pulsed; busy stays 0.
- Write 0x22/W with byte 0x11, then repeated START, then 0x22/R returning 0x77 -> start_det pulses twice; wr_data = 0x11; the read byte on SDA is 0x77.
- Assert rst during the 4th bit of a read byte while sda_oe = 1 -> sda_oe = 0 in the same cycle; after release, bus traffic is ignored until a new START, and a subsequent 0x22/W transfer is ACKed.
- With I2C_RESP_GLITCH_FILTER_EN defined, inject a 1-clk low glitch on SCL during WR_BYTE -> the bit count is unchanged and the received byte is correct.
